// File: rtl/output64_tx_pkg.sv
// Shared constants and FSM encoding for the 64-bit word to UART byte serializer.
package output64_tx_pkg;

    localparam int WORD_W      = 64;
    localparam int ACK_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_e;

endpackage

// File: rtl/output64_tx.sv
// Serializes 64-bit words into bytes for a UART TX, with a one-word holding
// register so a word arriving mid-transmission is queued rather than lost.
module output64_tx
    import output64_tx_pkg::*;
#(
    parameter int NUM_BYTES = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] dataOut,
    input  logic              dataOutValid,
    input  logic              uart_tx_busy,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    output logic              txBusy,
    output logic              dataOut64Done,
    output logic              dataDropped
);

    localparam logic [3:0] LAST_CNT = 4'(NUM_BYTES);
    localparam logic [2:0] ACK_LAST = 3'(ACK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              pend_valid_q, pend_valid_d;
    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [2:0]        ack_cnt_q, ack_cnt_d;
    logic              dropped_q, dropped_d;
    logic              tx_en;

    function automatic logic [7:0] cur_byte(input logic [WORD_W-1:0] s);
        if (MSB_FIRST) return s[WORD_W-1 -: 8];
        else           return s[7:0];
    endfunction

    function automatic logic [WORD_W-1:0] next_shift(input logic [WORD_W-1:0] s);
        if (MSB_FIRST) return {s[WORD_W-9:0], 8'h00};
        else           return {8'h00, s[WORD_W-1:8]};
    endfunction

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        pend_valid_d = pend_valid_q;
        byte_cnt_d   = byte_cnt_q;
        ack_cnt_d    = ack_cnt_q;
        dropped_d    = 1'b0;
        tx_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    shift_d      = hold_q;
                    pend_valid_d = 1'b0;
                    state_d      = SEND;
                end else if (dataOutValid) begin
                    shift_d = dataOut;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!uart_tx_busy) begin
                    tx_en     = 1'b1;
                    ack_cnt_d = 3'd0;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // A UART that never raised busy missed the strobe; resend the same byte.
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    state_d = SEND;
                end else begin
                    ack_cnt_d = ack_cnt_q + 3'd1;
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    shift_d    = next_shift(shift_q);
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    state_d    = (byte_cnt_d == LAST_CNT) ? FINISH : SEND;
                end
            end
            FINISH: begin
                byte_cnt_d = 4'd0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // In IDLE the pending slot is freed this cycle, so a new word always fits there.
        if (dataOutValid && !(state_q == IDLE && !pend_valid_q)) begin
            if (!pend_valid_q || state_q == IDLE) begin
                hold_d       = dataOut;
                pend_valid_d = 1'b1;
            end else begin
                dropped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            pend_valid_q <= 1'b0;
            byte_cnt_q   <= 4'd0;
            ack_cnt_q    <= 3'd0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            pend_valid_q <= pend_valid_d;
            byte_cnt_q   <= byte_cnt_d;
            ack_cnt_q    <= ack_cnt_d;
            dropped_q    <= dropped_d;
        end
    end

    assign uart_tx_en    = tx_en;
    assign uart_tx_data  = cur_byte(shift_q);
    assign txBusy        = (state_q != IDLE) || pend_valid_q;
    assign dataOut64Done = (state_q == FINISH);
    assign dataDropped   = dropped_q;

endmodule

// File: tb/tb_output64_tx.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) beside simple UART models.
module tb_output64_tx;

    logic        clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset = 1'b1;
    logic        dvalid = 1'b0;
    logic [63:0] dword = 64'd0;

    logic        busy0, busy1, en0, en1, txb0, txb1, done0, done1, drop0, drop1;
    logic [7:0]  data0, data1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];

    int          cnt0 = 0, cnt1 = 0;
    int          ign_req = 0, ign_used0 = 0, ign_used1 = 0;
    logic        hold_busy = 1'b0;
    logic        line_vld0 = 1'b0, line_vld1 = 1'b0;
    logic [7:0]  line_b0 = 8'd0, line_b1 = 8'd0;
    int          lines0 = 0, lines1 = 0;
    int          dones0 = 0, dones1 = 0, drops0 = 0, drops1 = 0;
    int          en_in_hold = 0;
    int          exp_done = 0;

    assign busy0 = hold_busy || (cnt0 != 0);
    assign busy1 = hold_busy || (cnt1 != 0);

    output64_tx #(.NUM_BYTES(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .dataOut(dword), .dataOutValid(dvalid),
        .uart_tx_busy(busy0), .uart_tx_en(en0), .uart_tx_data(data0),
        .txBusy(txb0), .dataOut64Done(done0), .dataDropped(drop0));

    output64_tx #(.NUM_BYTES(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .dataOut(dword), .dataOutValid(dvalid),
        .uart_tx_busy(busy1), .uart_tx_en(en1), .uart_tx_data(data1),
        .txBusy(txb1), .dataOut64Done(done1), .dataDropped(drop1));

    // UART models: busy rises the cycle after an accepted strobe and stays high 10 cycles.
    always @(posedge clk) begin
        line_vld0 <= 1'b0;
        if (en0) begin
            if (ign_used0 < ign_req) ign_used0 <= ign_used0 + 1;
            else begin
                cnt0      <= 10;
                line_vld0 <= 1'b1;
                line_b0   <= data0;
            end
        end else if (cnt0 > 0) cnt0 <= cnt0 - 1;
    end

    always @(posedge clk) begin
        line_vld1 <= 1'b0;
        if (en1) begin
            if (ign_used1 < ign_req) ign_used1 <= ign_used1 + 1;
            else begin
                cnt1      <= 10;
                line_vld1 <= 1'b1;
                line_b1   <= data1;
            end
        end else if (cnt1 > 0) cnt1 <= cnt1 - 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_byte(input int idx, input logic [7:0] b);
        logic [7:0] e;
        if (idx == 0) begin
            lines0++;
            if (exp_q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL line_byte_msb: got %0h, want no byte", b);
            end else begin
                e = exp_q0.pop_front();
                chk("line_byte_msb", 64'(b), 64'(e));
            end
        end else begin
            lines1++;
            if (exp_q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL line_byte_lsb: got %0h, want no byte", b);
            end else begin
                e = exp_q1.pop_front();
                chk("line_byte_lsb", 64'(b), 64'(e));
            end
        end
    endtask

    // Monitor: compares bytes as they reach the line, tallies pulses.
    always @(negedge clk) begin
        if (line_vld0) check_byte(0, line_b0);
        if (line_vld1) check_byte(1, line_b1);
        if (done0) dones0++;
        if (done1) dones1++;
        if (drop0) drops0++;
        if (drop1) drops1++;
        if (hold_busy && (en0 || en1)) en_in_hold++;
    end

    // Expected byte streams are written out by hand, first byte in bits [63:56].
    task automatic push_exp(input logic [63:0] s_msb, input logic [63:0] s_lsb, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q0.push_back(s_msb[63-8*i -: 8]);
            exp_q1.push_back(s_lsb[63-8*i -: 8]);
        end
    endtask

    task automatic send(input logic [63:0] w);
        @(negedge clk);
        dword  = w;
        dvalid = 1'b1;
        @(negedge clk);
        dvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while ((txb0 || txb1 || cnt0 != 0 || cnt1 != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_cmp++;
        if (k >= 3000) begin
            n_bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", name, k);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},   64'({en0, en1}),     64'd0);
        chk({tag, "_data"}, 64'({data0, data1}), 64'd0);
        chk({tag, "_busy"}, 64'({txb0, txb1}),   64'd0);
        chk({tag, "_done"}, 64'({done0, done1}), 64'd0);
        chk({tag, "_drop"}, 64'({drop0, drop1}), 64'd0);
    endtask

    initial begin
        int k;
        int l0;
        int d0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("post_reset");

        // Single word, both byte orders
        push_exp(64'h0123456789ABCDEF, 64'hEFCDAB8967452301, 8);
        send(64'h0123456789ABCDEF);
        wait_idle("word1");
        exp_done += 1;
        chk("word1_done_msb", 64'(dones0), 64'(exp_done));
        chk("word1_done_lsb", 64'(dones1), 64'(exp_done));

        // Three words one cycle apart: A sent, B queued, C dropped
        push_exp(64'h1122334455667788, 64'h8877665544332211, 8);
        push_exp(64'h99AABBCCDDEEFF00, 64'h00FFEEDDCCBBAA99, 8);
        send(64'h1122334455667788);
        send(64'h99AABBCCDDEEFF00);
        send(64'hDEADBEEFCAFEF00D);
        wait_idle("abc");
        exp_done += 2;
        chk("abc_done_msb", 64'(dones0), 64'(exp_done));
        chk("abc_done_lsb", 64'(dones1), 64'(exp_done));
        chk("abc_drop_msb", 64'(drops0), 64'd1);
        chk("abc_drop_lsb", 64'(drops1), 64'd1);

        // UART misses the first strobe; byte must be resent
        l0 = lines0;
        ign_req = 1;
        push_exp(64'h0F1E2D3C4B5A6978, 64'h78695A4B3C2D1E0F, 8);
        send(64'h0F1E2D3C4B5A6978);
        wait_idle("resend");
        exp_done += 1;
        chk("resend_ignored", 64'(ign_used0 + ign_used1), 64'd2);
        chk("resend_line_bytes", 64'(lines0 - l0), 64'd8);
        chk("resend_done", 64'(dones0), 64'(exp_done));

        // Reset after the third byte abandons the word
        l0 = lines0;
        d0 = dones0;
        push_exp(64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 3);
        send(64'hAAAAAAAAAAAAAAAA);
        k = 0;
        while (lines0 - l0 < 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("abort_reached_byte3", 64'(lines0 - l0 >= 3), 64'd1);
        reset  = 1'b1;
        dword  = 64'hFFFFFFFFFFFFFFFF;
        dvalid = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort");
        reset  = 1'b0;
        dvalid = 1'b0;
        wait_idle("abort");
        chk("abort_no_done", 64'(dones0 + dones1), 64'(2 * d0));
        chk("abort_lines", 64'(lines0 - l0), 64'd3);
        push_exp(64'h5555555555555555, 64'h5555555555555555, 8);
        send(64'h5555555555555555);
        wait_idle("after_abort");
        exp_done += 1;
        chk("after_abort_done", 64'(dones1), 64'(exp_done));

        // Busy held high before the first byte
        hold_busy = 1'b1;
        push_exp(64'h8877665544332211, 64'h1122334455667788, 8);
        send(64'h8877665544332211);
        repeat (20) @(negedge clk);
        chk("held_txbusy", 64'({txb0, txb1}), 64'b11);
        chk("held_no_send", 64'(lines0 + lines1), 64'(2 * (l0 + 11)));
        hold_busy = 1'b0;
        wait_idle("held");
        exp_done += 1;
        chk("held_en_gated", 64'(en_in_hold), 64'd0);
        chk("held_done", 64'(dones0), 64'(exp_done));

        chk("final_queue_msb", 64'(exp_q0.size()), 64'd0);
        chk("final_queue_lsb", 64'(exp_q1.size()), 64'd0);
        chk("final_drops", 64'(drops0 + drops1), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/output64_tx.md
OUTPUT64_TX -- requirements
Module: output64_tx

Interface
REQ-001 SHALL have parameter NUM_BYTES, default 8, bytes sent per word (fixed 8 in this release; other values unsupported).
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = byte [63:56] sent first, 0 = byte [7:0] sent first.
REQ-003 SHALL have port clk  input  1  50MHz system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port dataOut  input  64  word to transmit.
REQ-006 SHALL have port dataOutValid  input  1  one-cycle pulse; dataOut valid in that cycle.
REQ-007 SHALL have port uart_tx_busy  input  1  UART TX busy flag.
REQ-008 SHALL have port uart_tx_en  output  1  one-cycle send strobe to UART TX.
REQ-009 SHALL have port uart_tx_data  output  8  byte presented with uart_tx_en.
REQ-010 SHALL have port txBusy  output  1  high while any word is held or being sent.
REQ-011 SHALL have port dataOut64Done  output  1  one-cycle pulse after last byte of a word completes.
REQ-012 SHALL have port dataDropped  output  1  one-cycle pulse when an incoming word is discarded.

Function
REQ-013 SHALL hold one shift register (active word) plus one 64-bit holding register (pending word, with pendValid flag).
REQ-014 SHALL use FSM states IDLE, SEND, WAIT_ACK, WAIT_DONE, FINISH.
REQ-015 IDLE: if pendValid, move pending word to shift register, clear pendValid, go SEND; else if dataOutValid, load dataOut directly into shift register, go SEND.
REQ-016 SEND: when uart_tx_busy low, drive uart_tx_en=1 for exactly one cycle with current byte, go WAIT_ACK; while busy high, wait in SEND.
REQ-017 WAIT_ACK: go WAIT_DONE on uart_tx_busy high; if busy not seen high within 4 cycles, return to SEND and resend the same byte.
REQ-018 WAIT_DONE: on uart_tx_busy low, shift register by 8 bits toward the next byte, increment byteCnt; if byteCnt reaches NUM_BYTES go FINISH, else SEND.
REQ-019 FINISH: pulse dataOut64Done one cycle, clear byteCnt, go IDLE.
REQ-020 byteCnt SHALL be 4 bits, count 0..NUM_BYTES, never wrap.
REQ-021 dataOutValid in any state other than that consumed by REQ-015: if pendValid=0, capture into holding register, set pendValid; if pendValid=1, discard word and pulse dataDropped next cycle.
REQ-022 dataOutValid in IDLE with pendValid=1: pending word goes to shift register and new word goes to holding register in the same cycle; no drop.
REQ-023 Minimum gap: IDLE to first uart_tx_en SHALL be 1 cycle after load; back-to-back words SHALL incur FINISH+IDLE = 2 cycles between last byte done and next uart_tx_en.
REQ-024 txBusy SHALL be high when state != IDLE or pendValid=1.
REQ-025 uart_tx_data SHALL be stable from uart_tx_en cycle until WAIT_DONE exit.

Reset
REQ-026 On reset high at a clk edge: state IDLE, byteCnt 0, pendValid 0, shift and holding registers 0, uart_tx_en 0, uart_tx_data 0, dataOut64Done 0, dataDropped 0, txBusy 0.
REQ-027 Reset mid-word SHALL abandon the word with no dataOut64Done pulse; dataOutValid during reset SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding, the 4-cycle ACK_TIMEOUT constant, and the 64-bit word width constant.
REQ-029 Single module, no sub-modules; instantiated beside the existing UART TX, whose en/busy/data it drives and reads.

Verification
REQ-030 Word 0x0123456789ABCDEF, MSB_FIRST=1, UART model busy 1 cycle after en for 10 cycles -> bytes 01,23,45,67,89,AB,CD,EF in order; one dataOut64Done pulse after EF.
REQ-031 MSB_FIRST=0, same word -> bytes EF,CD,AB,89,67,45,23,01.
REQ-032 Three pulses 1 cycle apart (A,B,C) while sending -> A and B transmitted in order, C dropped with one dataDropped pulse; two dataOut64Done pulses.
REQ-033 UART model ignores first en (busy stays low) -> byte resent after 4 cycles; exactly 8 distinct bytes reach the line.
REQ-034 Reset asserted after 3rd byte of 0xAAAAAAAAAAAAAAAA -> all outputs at reset values next cycle; no dataOut64Done; next word 0x5555555555555555 sent in full.
REQ-035 uart_tx_busy held high 20 cycles before first byte -> uart_tx_en not asserted until busy falls.
